// File: rtl/me_pkg.sv
// Shared widths, stream ids and lane helpers for the motion-estimation pixel feeder.
package me_pkg;

    localparam int PIX_W     = 8;
    localparam int CUR_BUS_W = 32;
    localparam int REF_BUS_W = 64;
    localparam int MEM_W     = 64;

    typedef enum logic {
        STRM_CUR = 1'b0,
        STRM_REF = 1'b1
    } strm_e;

    // Byte 0 of the current frame sits in the low lane, so half 0 is the low 32 bits.
    function automatic logic [CUR_BUS_W-1:0] cur_half(input logic [MEM_W-1:0] word,
                                                      input logic             half);
        return half ? word[MEM_W-1:CUR_BUS_W] : word[CUR_BUS_W-1:0];
    endfunction

endpackage

// File: rtl/me_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible on dout while not empty.
module me_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/me_pixel_feeder.sv
// Serves ME pixel requests from per-stream prefetch FIFOs and keeps them topped up
// with in-order 64-bit frame-buffer reads, tagged by stream.
module me_pixel_feeder
    import me_pkg::*;
#(
    parameter logic [31:0] CUR_BASE  = 32'h0000_0000,
    parameter logic [31:0] REF_BASE  = 32'h0080_0000,
    parameter int          CUR_BYTES = 8294400,
    parameter int          REF_BYTES = 23945760,
    parameter int          DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 need_cur,
    input  logic                 need_ref,
    output logic [CUR_BUS_W-1:0] cur_in,
    output logic [REF_BUS_W-1:0] ref_in,
    output logic                 cur_vld,
    output logic                 ref_vld,
    output logic                 cur_wrap,
    output logic                 ref_wrap,
    output logic                 mem_rd_req,
    output logic [31:0]          mem_rd_addr,
    input  logic                 mem_rd_gnt,
    input  logic                 mem_rd_vld,
    input  logic [MEM_W-1:0]     mem_rd_data
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SUM_W = CNT_W + 1;
    localparam int TAG_CW = $clog2(2*DEPTH+1);

    logic [MEM_W-1:0]  cur_head, ref_head;
    logic              cur_full, cur_empty, ref_full, ref_empty;
    logic [CNT_W-1:0]  cur_cnt, ref_cnt;
    logic [0:0]        tag_head, tag_din;
    logic              tag_full, tag_empty;
    logic [TAG_CW-1:0] tag_cnt;
    logic              tag_unused;

    logic [CNT_W-1:0]  out_cur, out_ref;
    logic [31:0]       off_cur, off_ref, off_cur_nxt, off_ref_nxt;
    logic              half;
    strm_e             req_strm;

    logic              gnt_any, gnt_cur, gnt_ref;
    logic              ret_ok, ret_cur, ret_ref;
    logic              serve_cur, serve_ref, pop_cur, pop_ref;
    logic              hit_cur_end, hit_ref_end;
    logic [SUM_W-1:0]  sum_cur, sum_ref, sum_cur_nxt, sum_ref_nxt;
    logic              elig_cur, elig_ref, pick_ref;

    // Returns during reset are stale by construction; drop them.
    assign ret_ok  = mem_rd_vld & ~rst & ~tag_empty;
    assign ret_cur = ret_ok & (strm_e'(tag_head) == STRM_CUR);
    assign ret_ref = ret_ok & (strm_e'(tag_head) == STRM_REF);

    assign gnt_any = mem_rd_req & mem_rd_gnt & ~rst;
    assign gnt_cur = gnt_any & (req_strm == STRM_CUR);
    assign gnt_ref = gnt_any & (req_strm == STRM_REF);
    assign tag_din = 1'(req_strm);

    assign serve_cur = need_cur & ~cur_empty;
    assign serve_ref = need_ref & ~serve_cur & ~ref_empty;
    assign pop_cur   = serve_cur & half;
    assign pop_ref   = serve_ref;

    assign tag_unused = ^{cur_full, ref_full, tag_full, tag_cnt};

    me_sync_fifo #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_cur_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_cur),
        .din   (mem_rd_data),
        .pop   (pop_cur),
        .dout  (cur_head),
        .full  (cur_full),
        .empty (cur_empty),
        .count (cur_cnt)
    );

    me_sync_fifo #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_ref_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_ref),
        .din   (mem_rd_data),
        .pop   (pop_ref),
        .dout  (ref_head),
        .full  (ref_full),
        .empty (ref_empty),
        .count (ref_cnt)
    );

    me_sync_fifo #(.WIDTH(1), .DEPTH(2*DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_any),
        .din   (tag_din),
        .pop   (ret_ok),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

    // Fetch offsets advance per grant and fold back to the base at the end of each region.
    assign hit_cur_end = (off_cur + 32'd8 == 32'(CUR_BYTES));
    assign hit_ref_end = (off_ref + 32'd8 == 32'(REF_BYTES));

    always_comb begin
        off_cur_nxt = off_cur;
        off_ref_nxt = off_ref;
        if (gnt_cur) off_cur_nxt = hit_cur_end ? 32'd0 : off_cur + 32'd8;
        if (gnt_ref) off_ref_nxt = hit_ref_end ? 32'd0 : off_ref + 32'd8;
    end

    assign cur_wrap = gnt_cur & hit_cur_end;
    assign ref_wrap = gnt_ref & hit_ref_end;

    // A return moves a credit from out to occ, so only grants and pops change the sum.
    always_comb begin
        sum_cur     = SUM_W'(cur_cnt) + SUM_W'(out_cur);
        sum_ref     = SUM_W'(ref_cnt) + SUM_W'(out_ref);
        sum_cur_nxt = sum_cur + SUM_W'(gnt_cur) - SUM_W'(pop_cur);
        sum_ref_nxt = sum_ref + SUM_W'(gnt_ref) - SUM_W'(pop_ref);
        elig_cur    = (sum_cur_nxt < SUM_W'(DEPTH));
        elig_ref    = (sum_ref_nxt < SUM_W'(DEPTH));
        pick_ref    = elig_ref & (~elig_cur | (sum_ref_nxt < sum_cur_nxt));
    end

    // Issue stage: a raised request holds stream and address until granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_req  <= 1'b0;
            req_strm    <= STRM_CUR;
            mem_rd_addr <= CUR_BASE;
        end else if (!mem_rd_req || mem_rd_gnt) begin
            mem_rd_req  <= elig_cur | elig_ref;
            req_strm    <= pick_ref ? STRM_REF : STRM_CUR;
            mem_rd_addr <= pick_ref ? (REF_BASE + off_ref_nxt) : (CUR_BASE + off_cur_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_cur <= '0;
            off_ref <= '0;
            out_cur <= '0;
            out_ref <= '0;
        end else begin
            off_cur <= off_cur_nxt;
            off_ref <= off_ref_nxt;
            out_cur <= out_cur + CNT_W'(gnt_cur) - CNT_W'(ret_cur);
            out_ref <= out_ref + CNT_W'(gnt_ref) - CNT_W'(ret_ref);
        end
    end

    // Serve stage: one stream per cycle, result registered for the ME.
    always_ff @(posedge clk) begin
        if (rst) begin
            half    <= 1'b0;
            cur_vld <= 1'b0;
            ref_vld <= 1'b0;
            cur_in  <= '0;
            ref_in  <= '0;
        end else begin
            cur_vld <= serve_cur;
            ref_vld <= serve_ref;
            if (serve_cur) begin
                cur_in <= cur_half(cur_head, half);
                half   <= ~half;
            end
            if (serve_ref) ref_in <= ref_head;
        end
    end

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Scoreboard bench: ME-style requester plus an in-order frame-buffer model with random latency.
module tb_me_pixel_feeder;

    localparam logic [31:0] CUR_BASE  = 32'h0000_0000;
    localparam logic [31:0] REF_BASE  = 32'h0080_0000;
    localparam int          CUR_BYTES = 16;
    localparam int          REF_BYTES = 64;
    localparam int          DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        need_cur = 1'b0, need_ref = 1'b0;
    logic [31:0] cur_in;
    logic [63:0] ref_in;
    logic        cur_vld, ref_vld, cur_wrap, ref_wrap;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_gnt = 1'b0, mem_rd_vld = 1'b0;
    logic [63:0] mem_rd_data = '0;

    me_pixel_feeder #(
        .CUR_BASE(CUR_BASE), .REF_BASE(REF_BASE),
        .CUR_BYTES(CUR_BYTES), .REF_BYTES(REF_BYTES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref),
        .cur_in(cur_in), .ref_in(ref_in), .cur_vld(cur_vld), .ref_vld(ref_vld),
        .cur_wrap(cur_wrap), .ref_wrap(ref_wrap),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_vld(mem_rd_vld), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } rd_t;

    rd_t         inflight[$];
    logic [31:0] exp_cur_q[$];
    logic [63:0] exp_ref_q[$];
    int          n_cmp = 0, n_err = 0, cyc = 0;
    int          cur_pos = 0, ref_pos = 0;
    logic [31:0] nxt_cur_addr = CUR_BASE, nxt_ref_addr = REF_BASE;
    bit          pend_cur = 0, pend_ref = 0, want_cur = 0, want_ref = 0, gnt_en = 0;
    int          gnt_pct = 100, vld_pct = 100, lat_max = 2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return a[7:0] ^ ((a >= REF_BASE) ? 8'h80 : 8'h00);
    endfunction

    function automatic logic [63:0] word_at(input logic [31:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = byte_at(a + 32'(k));
        return w;
    endfunction

    function automatic logic [31:0] cur_exp(input int pos);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = byte_at(CUR_BASE + 32'(pos + k));
        return v;
    endfunction

    task automatic step();
        bit          exp_wrap;
        logic [31:0] exp_addr;
        @(negedge clk);
        cyc++;
        if (cur_vld) begin
            if (exp_cur_q.size() == 0) chk("cur_spurious_vld", 1, 0);
            else chk("cur_data", 64'(cur_in), 64'(exp_cur_q.pop_front()));
            pend_cur = 0;
        end
        if (ref_vld) begin
            if (exp_ref_q.size() == 0) chk("ref_spurious_vld", 1, 0);
            else chk("ref_data", ref_in, exp_ref_q.pop_front());
            pend_ref = 0;
        end
        chk("credit_cur", 64'(dut.sum_cur <= 4'(DEPTH)), 1);
        chk("credit_ref", 64'(dut.sum_ref <= 4'(DEPTH)), 1);
        if (!pend_cur && want_cur) begin
            exp_cur_q.push_back(cur_exp(cur_pos));
            cur_pos = (cur_pos + 4) % CUR_BYTES;
            pend_cur = 1;
        end
        if (!pend_ref && want_ref) begin
            exp_ref_q.push_back(word_at(REF_BASE + 32'(ref_pos)));
            ref_pos = (ref_pos + 8) % REF_BYTES;
            pend_ref = 1;
        end
        need_cur = pend_cur;
        need_ref = pend_ref;
        mem_rd_vld  = 1'b0;
        mem_rd_data = '0;
        if (inflight.size() > 0 && inflight[0].ready <= cyc && $urandom_range(99) < vld_pct) begin
            mem_rd_vld  = 1'b1;
            mem_rd_data = word_at(inflight[0].addr);
            void'(inflight.pop_front());
        end
        mem_rd_gnt = gnt_en && ($urandom_range(99) < gnt_pct);
        #1;
        if (mem_rd_req && mem_rd_gnt) begin
            if (mem_rd_addr >= REF_BASE) begin
                exp_addr = nxt_ref_addr;
                exp_wrap = (nxt_ref_addr == REF_BASE + 32'(REF_BYTES - 8));
                chk("ref_addr", 64'(mem_rd_addr), 64'(exp_addr));
                chk("wrap_on_ref_gnt", {cur_wrap, ref_wrap}, {1'b0, exp_wrap});
                nxt_ref_addr = exp_wrap ? REF_BASE : nxt_ref_addr + 32'd8;
            end else begin
                exp_addr = nxt_cur_addr;
                exp_wrap = (nxt_cur_addr == CUR_BASE + 32'(CUR_BYTES - 8));
                chk("cur_addr", 64'(mem_rd_addr), 64'(exp_addr));
                chk("wrap_on_cur_gnt", {cur_wrap, ref_wrap}, {exp_wrap, 1'b0});
                nxt_cur_addr = exp_wrap ? CUR_BASE : nxt_cur_addr + 32'd8;
            end
            inflight.push_back('{mem_rd_addr, cyc + 1 + int'($urandom_range(lat_max))});
        end else begin
            chk("wrap_idle", {cur_wrap, ref_wrap}, 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_cycles(input int n, input bit junk_returns);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            need_cur    = 1'($urandom);
            need_ref    = 1'($urandom);
            mem_rd_gnt  = 1'($urandom);
            mem_rd_vld  = junk_returns;
            mem_rd_data = 64'hDEAD_BEEF_CAFE_F00D;
            @(negedge clk);
            chk("rst_cur_in", 64'(cur_in), 0);
            chk("rst_ref_in", ref_in, 0);
            chk("rst_ctl", {cur_vld, ref_vld, cur_wrap, ref_wrap, mem_rd_req}, 0);
            chk("rst_addr", 64'(mem_rd_addr), 64'(CUR_BASE));
        end
        inflight.delete();
        exp_cur_q.delete();
        exp_ref_q.delete();
        pend_cur = 0; pend_ref = 0; want_cur = 0; want_ref = 0;
        cur_pos = 0; ref_pos = 0;
        nxt_cur_addr = CUR_BASE; nxt_ref_addr = REF_BASE;
        need_cur = 1'b0; need_ref = 1'b0;
        mem_rd_gnt = 1'b0; mem_rd_vld = 1'b0; mem_rd_data = '0;
        rst = 1'b0;
    endtask

    initial begin
        // Power-on reset with random needs, then grants held off to check request lock.
        reset_cycles(3, 1'b0);
        gnt_en = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_req", 64'(mem_rd_req), 1);
            chk("bp_addr", 64'(mem_rd_addr), 64'(CUR_BASE));
        end
        gnt_en = 1; gnt_pct = 100; vld_pct = 100; lat_max = 2;
        run(20);

        // Cur stream: two consecutive halves of the first word.
        want_cur = 1;
        step();
        step();
        chk("cur_first_vld", 64'(cur_vld), 1);
        want_cur = 0;
        step();
        chk("cur_second_vld", 64'(cur_vld), 1);
        run(10);

        // Priority: cur wins twice, then ref is served.
        want_cur = 1; want_ref = 1;
        step();
        step();
        chk("prio_c1", {cur_vld, ref_vld}, 2'b10);
        want_cur = 0;
        step();
        chk("prio_c2", {cur_vld, ref_vld}, 2'b10);
        step();
        chk("prio_r", {cur_vld, ref_vld}, 2'b01);
        want_ref = 0;
        run(10);

        // Random traffic with grant and return stalls.
        gnt_pct = 70; vld_pct = 70; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            want_cur = ($urandom_range(99) < 70);
            want_ref = ($urandom_range(99) < 60);
            step();
        end

        // Mid-run reset with reads outstanding; junk returns during reset must be ignored.
        vld_pct = 15; gnt_pct = 100;
        for (int i = 0; i < 8; i++) begin
            want_cur = 1'($urandom);
            want_ref = 1'($urandom);
            step();
        end
        reset_cycles(2, 1'b1);
        vld_pct = 100; lat_max = 2;
        run(15);
        want_cur = 1;
        step();
        want_cur = 0;
        step();
        chk("post_rst_cur_vld", 64'(cur_vld), 1);

        // Drain everything still requested.
        want_cur = 0; want_ref = 0;
        for (int i = 0; i < 200 && (pend_cur || pend_ref); i++) step();
        chk("drain_cur", 64'(exp_cur_q.size()), 0);
        chk("drain_ref", 64'(exp_ref_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
